// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer write scheduler:
// buffer geometry, field widths and scheduler state encodings.
package fb_pkg;

    localparam int FB_W = 400;
    localparam int FB_H = 225;
    localparam int X_W  = 9;
    localparam int Y_W  = 8;
    localparam int D_W  = 6;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_rr_arb.sv
// Combinational round-robin arbiter: search begins one past ptr_i,
// wraps modulo N_REQ, and skips requesters masked by mask_i.
module fb_rr_arb
    import fb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PW    = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PW-1:0]    idx_o,
    output logic             valid_o
);

    logic [N_REQ-1:0] eff;

    // First eligible requester after the last grant wins.
    always_comb begin
        int j;
        eff     = req_i & ~mask_i;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr_i) + 1 + i) % N_REQ;
            if (!valid_o && eff[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/fb_wr_sched.sv
// Frame-buffer write-port scheduler: round-robin pixel writers
// plus a full-buffer clear engine, all outputs registered.
module fb_wr_sched
    import fb_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int FB_W         = fb_pkg::FB_W,
    parameter int FB_H         = fb_pkg::FB_H,
    parameter bit CLR_ON_VSYNC = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_vsync,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [9*N_REQ-1:0] i_x,
    input  logic [8*N_REQ-1:0] i_y,
    input  logic [6*N_REQ-1:0] i_data,
    output logic [N_REQ-1:0]   o_ack,
    input  logic               i_clr_start,
    input  logic [5:0]         i_clr_color,
    output logic               o_we,
    output logic [8:0]         o_x,
    output logic [7:0]         o_y,
    output logic [5:0]         o_data,
    output logic               o_busy,
    output logic               o_clr_done,
    output logic               o_drop
);

    localparam int PW = ptr_w(N_REQ);
    localparam logic [X_W-1:0] XL = X_W'(FB_W - 1);
    localparam logic [Y_W-1:0] YL = Y_W'(FB_H - 1);

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             we_q, we_d;
    logic             drop_q, drop_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             vsync_q;
    logic [X_W-1:0]   x_q, x_d, cx_q, cx_d;
    logic [Y_W-1:0]   y_q, y_d, cy_q, cy_d;
    logic [D_W-1:0]   data_q, data_d, col_q, col_d;

    logic [N_REQ-1:0] gnt;
    logic [PW-1:0]    gidx;
    logic             gvalid;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [D_W-1:0]   sel_d;
    logic             in_rng;
    logic             arb_en;

    // Last-cycle acks are masked so nobody is written twice in a row.
    fb_rr_arb #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req_i   (i_req),
        .mask_i  (ack_q),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gidx),
        .valid_o (gvalid)
    );

    // Operand mux for the granted requester and its range check.
    always_comb begin
        sel_x  = i_x[int'(gidx)*X_W +: X_W];
        sel_y  = i_y[int'(gidx)*Y_W +: Y_W];
        sel_d  = i_data[int'(gidx)*D_W +: D_W];
        in_rng = (sel_x <= XL) && (sel_y <= YL);
    end

    // Next-state: FSM, clear counters, arbitration and output values.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        we_d    = 1'b0;
        x_d     = '0;
        y_d     = '0;
        data_d  = '0;
        drop_d  = 1'b0;
        done_d  = 1'b0;
        cx_d    = cx_q;
        cy_d    = cy_q;
        col_d   = col_q;
        arb_en  = 1'b0;

        unique case (state_q)
            S_RUN: begin
                arb_en = 1'b1;
                if (i_clr_start) begin
                    col_d   = i_clr_color;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = CLR_ON_VSYNC ? S_WAIT : S_CLEAR;
                end
            end
            S_WAIT: begin
                arb_en = 1'b1;
                if (i_vsync && !vsync_q) begin
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                we_d   = 1'b1;
                x_d    = cx_q;
                y_d    = cy_q;
                data_d = col_q;
                if (cx_q == XL) begin
                    cx_d = '0;
                    if (cy_q == YL) begin
                        cy_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        if (arb_en && gvalid) begin
            ack_d = gnt;
            ptr_d = gidx;
            if (in_rng) begin
                we_d   = 1'b1;
                x_d    = sel_x;
                y_d    = sel_y;
                data_d = sel_d;
            end else begin
                drop_d = 1'b1;
            end
        end

        busy_d = (state_d == S_WAIT) || (state_d == S_CLEAR);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_RUN;
            ptr_q   <= PW'(N_REQ - 1);
            ack_q   <= '0;
            we_q    <= 1'b0;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vsync_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vsync_q <= i_vsync;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_we       = we_q;
    assign o_x        = x_q;
    assign o_y        = y_q;
    assign o_data     = data_q;
    assign o_busy     = busy_q;
    assign o_clr_done = done_q;
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_fb_wr_sched.sv
// Directed bench for fb_wr_sched: a full-size vsync-gated instance
// and a small immediate-clear instance share one stimulus set.
module tb_fb_wr_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vsync;
    logic        clr_start;
    logic [5:0]  clr_col;
    logic [2:0]  req;
    logic [26:0] xb;
    logic [23:0] yb;
    logic [17:0] db;

    logic [2:0] a_ack, b_ack;
    logic       a_we, b_we, a_busy, b_busy;
    logic       a_done, b_done, a_drop, b_drop;
    logic [8:0] a_x, b_x;
    logic [7:0] a_y, b_y;
    logic [5:0] a_d, b_d;

    int n_cmp = 0;
    int n_bad = 0;

    fb_wr_sched #(.N_REQ(3), .CLR_ON_VSYNC(1'b1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_vsync(vsync),
        .i_req(req), .i_x(xb), .i_y(yb), .i_data(db),
        .o_ack(a_ack), .i_clr_start(clr_start),
        .i_clr_color(clr_col), .o_we(a_we),
        .o_x(a_x), .o_y(a_y), .o_data(a_d),
        .o_busy(a_busy), .o_clr_done(a_done),
        .o_drop(a_drop)
    );

    fb_wr_sched #(.N_REQ(3), .FB_W(8), .FB_H(4),
                  .CLR_ON_VSYNC(1'b0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_vsync(vsync),
        .i_req(req), .i_x(xb), .i_y(yb), .i_data(db),
        .o_ack(b_ack), .i_clr_start(clr_start),
        .i_clr_color(clr_col), .o_we(b_we),
        .o_x(b_x), .o_y(b_y), .o_data(b_d),
        .o_busy(b_busy), .o_clr_done(b_done),
        .o_drop(b_drop)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input int k, input logic [8:0] x,
                         input logic [7:0] y, input logic [5:0] d);
        xb[9*k +: 9] = x;
        yb[8*k +: 8] = y;
        db[6*k +: 6] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [2:0] exp_ack [9] = '{3'b001, 3'b010, 3'b100,
                                3'b001, 3'b010, 3'b100,
                                3'b001, 3'b010, 3'b100};
    logic [8:0] exp_x3 [3] = '{9'd1, 9'd2, 9'd3};

    initial begin
        int nw, nack, nbusy, err, ndone, ex, ey, lx, ly;
        bit seen;
        rst = 1'b1; vsync = 1'b0; clr_start = 1'b0;
        clr_col = '0; req = '0; xb = '0; yb = '0; db = '0;

        // 1: reset values, then a single write from requester 0
        step(); step(); step();
        chk("rst_we",   a_we,   0);
        chk("rst_ack",  a_ack,  0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_drop", a_drop, 0);
        chk("rst_xyd",  {a_x, a_y, a_d}, 0);
        rst = 1'b0;
        set_r(0, 9'd5, 8'd7, 6'h2A);
        req = 3'b001;
        step();
        chk("t1_ack", a_ack, 3'b001);
        chk("t1_we",  a_we,  1);
        chk("t1_x",   a_x,   5);
        chk("t1_y",   a_y,   7);
        chk("t1_d",   a_d,   6'h2A);
        req = 3'b000;
        step();
        chk("t1_idle_ack", a_ack, 0);
        chk("t1_idle_we",  a_we,  0);

        // 2: three requesters held high, round-robin from 0
        do_reset();
        set_r(0, 9'd1, 8'd1, 6'h01);
        set_r(1, 9'd2, 8'd2, 6'h02);
        set_r(2, 9'd3, 8'd3, 6'h03);
        req = 3'b111;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("rr_ack", a_ack, exp_ack[i]);
            chk("rr_we",  a_we,  1);
            chk("rr_x",   a_x,   exp_x3[i % 3]);
        end
        req = 3'b000;
        step();

        // 3: out-of-range x then y
        set_r(1, 9'd400, 8'd0, 6'h05);
        req = 3'b010;
        step();
        chk("oor_x_ack",  a_ack,  3'b010);
        chk("oor_x_drop", a_drop, 1);
        chk("oor_x_we",   a_we,   0);
        req = 3'b000;
        step();
        chk("oor_idle_drop", a_drop, 0);
        set_r(1, 9'd0, 8'd225, 6'h05);
        req = 3'b010;
        step();
        chk("oor_y_ack",  a_ack,  3'b010);
        chk("oor_y_drop", a_drop, 1);
        chk("oor_y_we",   a_we,   0);
        req = 3'b000;
        step();
        set_r(1, 9'd399, 8'd224, 6'h06);
        req = 3'b010;
        step();
        chk("edge_we",   a_we,   1);
        chk("edge_drop", a_drop, 0);
        req = 3'b000;
        step();

        // 4: vsync-gated full clear, req0 served while waiting
        set_r(0, 9'd10, 8'd20, 6'h15);
        req = 3'b001;
        clr_col = 6'h3F;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("wait_busy", a_busy, 1);
        chk("wait_ack0", a_ack,  3'b001);
        nack = 0; nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_ack == 3'b001 && a_we) nack++;
            if (!a_busy) nbusy++;
        end
        chk("wait_grants",  nack,  10);
        chk("wait_busylow", nbusy, 0);
        vsync = 1'b1;
        step();
        nw = 0; nack = 0; err = 0; seen = 0;
        ex = 0; ey = 0; lx = 0; ly = 0;
        for (int c = 0; c < 95000; c++) begin
            step();
            if (a_we) begin
                if (nw == 0) begin
                    chk("clr_first_x", a_x,    0);
                    chk("clr_first_y", a_y,    0);
                    chk("clr_first_d", a_d,    6'h3F);
                    chk("clr_busy",    a_busy, 1);
                end
                if (a_x != ex[8:0] || a_y != ey[7:0] || a_d != 6'h3F)
                    err++;
                ex++;
                if (ex == 400) begin
                    ex = 0;
                    ey++;
                end
                lx = int'(a_x);
                ly = int'(a_y);
                nw++;
            end
            if (a_ack != 3'b000) nack++;
            if (a_done) begin
                seen = 1;
                break;
            end
        end
        vsync = 1'b0;
        chk("clr_done_seen", seen, 1);
        chk("clr_writes",    nw,   90000);
        chk("clr_order",     err,  0);
        chk("clr_last_x",    lx,   399);
        chk("clr_last_y",    ly,   224);
        chk("clr_no_ack",    nack, 0);
        chk("clr_done_we",   a_we, 0);
        step();
        chk("clr_done_pulse", a_done, 0);
        chk("post_clr_ack",   a_ack,  3'b001);
        chk("post_clr_busy",  a_busy, 0);
        req = 3'b000;
        step();

        // 5: reset in the middle of a clear
        clr_col = 6'h15;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        vsync = 1'b1;
        step();
        nw = 0;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (a_we) nw++;
            if (nw == 1000) break;
        end
        chk("mid_writes", nw, 1000);
        rst = 1'b1;
        vsync = 1'b0;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_we",   a_we,   0);
        chk("mid_rst_done", a_done, 0);
        ndone = 0; nw = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_done) ndone++;
            if (a_we) nw++;
        end
        chk("mid_no_done", ndone, 0);
        chk("mid_no_we",   nw,    0);
        clr_col = 6'h0A;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        vsync = 1'b1;
        step();
        step();
        chk("restart_we", a_we, 1);
        chk("restart_x",  a_x,  0);
        chk("restart_y",  a_y,  0);
        chk("restart_d",  a_d,  6'h0A);
        vsync = 1'b0;

        // 6: immediate clear on the small instance
        do_reset();
        set_r(2, 9'd6, 8'd3, 6'h11);
        req = 3'b100;
        clr_col = 6'h2C;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        req = 3'b000;
        chk("imm_ack",  b_ack,  3'b100);
        chk("imm_we",   b_we,   1);
        chk("imm_x",    b_x,    6);
        chk("imm_busy", b_busy, 1);
        step();
        chk("imm_first_x", b_x,  0);
        chk("imm_first_y", b_y,  0);
        chk("imm_first_d", b_d,  6'h2C);
        chk("imm_first_we", b_we, 1);
        nw = 1; ex = 1; ey = 0; err = 0; ndone = 0;
        for (int c = 0; c < 100; c++) begin
            clr_start = (c == 5);
            clr_col = (c == 5) ? 6'h01 : 6'h2C;
            step();
            if (b_we) begin
                if (b_x != ex[8:0] || b_y != ey[7:0] || b_d != 6'h2C)
                    err++;
                ex++;
                if (ex == 8) begin
                    ex = 0;
                    ey++;
                end
                nw++;
            end
            if (b_done) ndone++;
        end
        clr_start = 1'b0;
        chk("imm_writes", nw,    32);
        chk("imm_order",  err,   0);
        chk("imm_done",   ndone, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
